period_meter: RTL and testbench
===============================

# period_meter

Measures the period and high time of a slow square-wave input (a divided clock, tick or external pulse train), in counts of the system clock. It is the receiving end of our divided-clock outputs: the divider produces a slow waveform from a count, and this block recovers that count from the waveform. It sits beside the FND driver for divider self-check and display of measured rates. A one-cycle valid pulse is issued per completed period, and a loss-of-signal flag is raised after a timeout.

## Interface
- CNT_WIDTH, 25: width of the counter and of the `period` and `high_time` outputs.
- TIMEOUT, 20_000_000: number of cycles without a rising edge before loss of signal is declared. Must satisfy 2 ≤ TIMEOUT ≤ 2^CNT_WIDTH−1.

- clk  in  1: system clock.
- rst_n  in  1: reset. Asynchronous, active-low.
- sig_in  in  1: measured waveform. Asynchronous to clk.
- period  out  CNT_WIDTH: cycles between the last two detected rising edges.
- high_time  out  CNT_WIDTH: cycles from a rising edge to the following falling edge.
- meas_valid  out  1: one-cycle pulse when `period` and `high_time` update.
- no_signal  out  1: level. Set by timeout, cleared by the next valid measurement.

## Operation
- **Input conditioning.** `sig_in` passes through a 2-FF synchronizer followed by one history register.
  - rise = sync & ~prev
  - fall = ~sync & prev
- **Internal counter.** `cnt`, CNT_WIDTH bits.
- **States:**
  - **IDLE.** `cnt` holds at 0. On rise: `cnt` <= 1 and go to MEASURE. No output update on this first edge.
  - **MEASURE.** `cnt` increments by 1 each cycle.
    - On fall: `high_time` <= `cnt`.
    - On rise: `period` <= `cnt`, `meas_valid` <= 1, `no_signal` <= 0, `cnt` <= 1. Stay in MEASURE.
    - If `cnt` == TIMEOUT and no rise this cycle: `no_signal` <= 1, `cnt` <= 0, go to IDLE. `period` and `high_time` hold their last values.
- **Simultaneous events.**
  - Rise and the timeout compare in the same cycle: rise wins, a measurement is emitted and there is no timeout.
  - Rise and fall cannot coincide.
- **Missing falling edge.** If a period completes with no fall seen since the previous rise (stuck-high, then stuck-low glitch lost by the synchronizer), `high_time` keeps its previous value. The valid pulse is still issued.
- **Counter range.** The counter never wraps: TIMEOUT ≤ 2^CNT_WIDTH−1 guarantees that the timeout is reached before overflow.
- **Reset (asserted at any time, including mid-measurement):**
  - state = IDLE
  - `cnt`, `period`, `high_time` = 0
  - `meas_valid` = 0
  - `no_signal` = 0
  - synchronizer and history flops = 0

## Timing
- **Edge detection latency.** A `sig_in` transition first sampled at clk edge k is detected (rise or fall true) between edges k+1 and k+2. The outputs register at edge k+2.
- **Valid pulse.** `meas_valid` is high for exactly one cycle per completed period. No downstream ready handshake exists; consumers capture on the pulse.
- **Output stability.** `period` and `high_time` are registered and change only on the meas_valid cycle (high_time: on its fall cycle). They are stable at all other times.
- **Minimum measurable period.** 2 cycles; an input toggling every clk is undefined. The minimum high or low time is 1 cycle after synchronization.
- **Timeout cycle.** `no_signal` asserts on the edge after the cycle where `cnt` == TIMEOUT. That is TIMEOUT+1 cycles after the last detected rise.

## Structure
- Sub-module `sync_edge`: contains the 2-FF synchronizer, the history register and the rise/fall outputs. It takes the same clk/rst_n.
- Top level: FSM, counter and output registers.
- The shared package holds:
  - the state enum `pm_state_t` {PM_IDLE, PM_MEASURE}
  - the default CNT_WIDTH/TIMEOUT constants, so that the FND and divider blocks can share them.

## Test plan
- **Divider-shaped input.** `sig_in` = 50%-duty square, period 10 clk (high 5), TIMEOUT=100 → the first rise gives no pulse. Then `meas_valid` pulses every 10 cycles with `period`=10 and `high_time`=5. `no_signal` stays 0.
- **Asymmetric duty.** High 3, low 7 → `period`=10, `high_time`=3. Changing to high 7, low 13 → after one transitional period, `period`=20 and `high_time`=7.
- **Loss of signal.** TIMEOUT=100, input stops low after a valid measurement → `no_signal`=1 exactly 101 cycles after the last detected rise, with `period` and `high_time` holding. On restart, the first rise gives no pulse, the second rise pulses `meas_valid` and clears `no_signal`.
- **Boundary.** Input period exactly TIMEOUT=100 → valid measurement `period`=100 with no timeout. Period 101 → timeout, no pulse.
- **Reset mid-measure.** Assert rst_n low 4 cycles after a rise → all outputs are 0 immediately (async). After release, two rises are needed before the next `meas_valid`.
- **Minimum pulse.** 1-cycle high pulses every 6 clk → `period`=6, `high_time`=1.

Source files
------------

// File: rtl/period_meter_pkg.sv
// Shared types and default sizing for the period meter and its sibling
// divider / FND display blocks.
package period_meter_pkg;

  localparam int unsigned PM_CNT_WIDTH = 25;
  localparam int unsigned PM_TIMEOUT   = 20_000_000;

  typedef enum logic {
    PM_IDLE,
    PM_MEASURE
  } pm_state_t;

endpackage

// File: rtl/period_meter_sync_edge.sv
// Two-flop synchronizer plus history register; flags rising and falling
// edges of an asynchronous input.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise_c,
  output logic fall_c
);

  logic sync1_q, sync2_q, prev_q;
  logic sync1_d, sync2_d, prev_d;

  always_comb begin
    sync1_d = sig_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign rise_c = sync2_q & ~prev_q;
  assign fall_c = ~sync2_q & prev_q;

endmodule

// File: rtl/period_meter.sv
// Recovers period and high time of a slow square wave in system-clock counts,
// with a per-period valid pulse and a loss-of-signal flag.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = PM_CNT_WIDTH,
  parameter int unsigned TIMEOUT   = PM_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sig_in,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 meas_valid,
  output logic                 no_signal
);

  logic rise_c, fall_c;

  sync_edge u_sync_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  pm_state_t            state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] high_time_q, high_time_d;
  logic                 meas_valid_q, meas_valid_d;
  logic                 no_signal_q, no_signal_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= PM_IDLE;
      cnt_q        <= '0;
      period_q     <= '0;
      high_time_q  <= '0;
      meas_valid_q <= 1'b0;
      no_signal_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      meas_valid_q <= meas_valid_d;
      no_signal_q  <= no_signal_d;
    end
  end

  // A rise in the timeout cycle takes priority, so a period of exactly
  // TIMEOUT still yields a measurement.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    period_d     = period_q;
    high_time_d  = high_time_q;
    meas_valid_d = 1'b0;
    no_signal_d  = no_signal_q;
    case (state_q)
      PM_IDLE: begin
        cnt_d = '0;
        if (rise_c) begin
          cnt_d   = CNT_WIDTH'(1);
          state_d = PM_MEASURE;
        end
      end
      PM_MEASURE: begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (fall_c) begin
          high_time_d = cnt_q;
        end
        if (rise_c) begin
          period_d     = cnt_q;
          meas_valid_d = 1'b1;
          no_signal_d  = 1'b0;
          cnt_d        = CNT_WIDTH'(1);
        end else if (cnt_q == CNT_WIDTH'(TIMEOUT)) begin
          no_signal_d = 1'b1;
          cnt_d       = '0;
          state_d     = PM_IDLE;
        end
      end
      default: state_d = PM_IDLE;
    endcase
  end

  assign period     = period_q;
  assign high_time  = high_time_q;
  assign meas_valid = meas_valid_q;
  assign no_signal  = no_signal_q;

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: table-driven waveforms feeding a
// scoreboard, plus hand-written loss-of-signal and reset sequences.
module tb_period_meter;

  localparam int unsigned CW  = 16;
  localparam int unsigned TMO = 100;

  typedef struct packed {
    logic [CW-1:0] period;
    logic [CW-1:0] high;
  } exp_t;

  typedef struct {
    int            h;
    int            l;
    int            n;
    logic [CW-1:0] ep;
    logic [CW-1:0] eh;
    bit            tmo;
  } rec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sig_in;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          meas_valid;
  logic          no_signal;

  int   checks = 0;
  int   passes = 0;
  exp_t sb_q[$];
  bit   have_prev;
  rec_t prev;
  rec_t tbl[7];

  period_meter #(.CNT_WIDTH(CW), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .no_signal  (no_signal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  // Scoreboard: every valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && meas_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_pulse", 32'(meas_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("period", 32'(period), 32'(e.period));
        chk("high_time", 32'(high_time), 32'(e.high));
        chk("no_signal_on_valid", 32'(no_signal), 32'd0);
      end
    end
  end

  // Each rise completes the previous period unless that period timed out.
  task automatic drive_rec(input rec_t r);
    for (int p = 0; p < r.n; p++) begin
      sig_in = 1'b1;
      if (have_prev && !prev.tmo) sb_q.push_back('{prev.ep, prev.eh});
      have_prev = 1'b1;
      prev      = r;
      repeat (r.h) @(negedge clk);
      sig_in = 1'b0;
      repeat (r.l) @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    int wi;
    int rem;
    tbl[0] = '{5, 5, 4, CW'(10), CW'(5), 1'b0};
    tbl[1] = '{3, 7, 3, CW'(10), CW'(3), 1'b0};
    tbl[2] = '{7, 13, 3, CW'(20), CW'(7), 1'b0};
    tbl[3] = '{1, 5, 4, CW'(6), CW'(1), 1'b0};
    tbl[4] = '{50, 50, 2, CW'(100), CW'(50), 1'b0};
    tbl[5] = '{50, 51, 2, CW'(0), CW'(0), 1'b1};
    tbl[6] = '{4, 6, 3, CW'(10), CW'(4), 1'b0};

    have_prev = 1'b0;
    rst_n  = 1'b0;
    sig_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_period", 32'(period), 32'd0);
    chk("rst_high", 32'(high_time), 32'd0);
    chk("rst_valid", 32'(meas_valid), 32'd0);
    chk("rst_nosig", 32'(no_signal), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) drive_rec(tbl[i]);

    // Input stops low: timeout with outputs holding last measurement.
    repeat (120) @(negedge clk);
    chk("los_nosig", 32'(no_signal), 32'd1);
    chk("los_hold_period", 32'(period), 32'd10);
    chk("los_hold_high", 32'(high_time), 32'd4);

    // Restart: first rise gives nothing, second clears no_signal.
    have_prev = 1'b0;
    drive_rec('{5, 5, 1, CW'(10), CW'(5), 1'b0});
    chk("restart_nosig_held", 32'(no_signal), 32'd1);
    sig_in = 1'b1;
    sb_q.push_back('{CW'(10), CW'(5)});
    found = 1'b0;
    wi    = 0;
    for (int i = 1; i <= 8 && !found; i++) begin
      @(negedge clk);
      if (meas_valid) begin
        found = 1'b1;
        wi    = i;
      end
    end
    chk("restart_pulse_seen", 32'(found), 32'd1);
    rem = (wi < 5) ? 5 - wi : 0;
    repeat (rem) @(negedge clk);
    sig_in = 1'b0;
    repeat (99 - rem) @(negedge clk);
    chk("tmo_not_early", 32'(no_signal), 32'd0);
    @(negedge clk);
    chk("tmo_exact", 32'(no_signal), 32'd1);
    chk("tmo_hold_period", 32'(period), 32'd10);
    chk("tmo_hold_high", 32'(high_time), 32'd5);

    // Asynchronous reset mid-measurement.
    sig_in = 1'b1;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_period", 32'(period), 32'd0);
    chk("async_rst_high", 32'(high_time), 32'd0);
    chk("async_rst_valid", 32'(meas_valid), 32'd0);
    chk("async_rst_nosig", 32'(no_signal), 32'd0);
    sig_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n     = 1'b1;
    have_prev = 1'b0;
    drive_rec('{4, 4, 3, CW'(8), CW'(4), 1'b0});
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
